alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command-level controller for the 16-bit ALU datapath and its 12-channel one-hot result multiplexer.
- Accepts one opcode plus operands per valid/ready handshake. Decodes the opcode into the mux one-hot select and the add/sub mode, and drives the operands.
- Waits a programmable settle time, captures the mux result into an accumulator, and returns it on a valid/ready response channel.
- Sits between the instruction/test front end and the ALU operation modules.

Parameters:
- WIDTH, 16, datapath width of operands, result and accumulator.
- SEL_W, 12, width of the one-hot mux select.
- SETTLE_CYC, 1, cycles the select/operands are held before capture; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  4  opcode.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_use_acc  input  1  when 1, operand A is taken from the accumulator instead of cmd_a.
- alu_a  output  WIDTH  operand A to the ALU modules.
- alu_b  output  WIDTH  operand B to the ALU modules.
- alu_sub  output  1  0 = add, 1 = subtract, to the add/sub unit.
- alu_sel  output  SEL_W  one-hot mux select.
- alu_res  input  WIDTH  mux output.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  captured result.
- rsp_err  output  1  illegal opcode flag for this response.
- acc_out  output  WIDTH  current accumulator value.

Behaviour:
- Opcode map, with the one-hot bit driven on alu_sel:
  - 0 AND bit0
  - 1 OR bit1
  - 2 NOT bit2
  - 3 XOR bit3
  - 4 NAND bit4
  - 5 NOR bit5
  - 6 XNOR bit6
  - 7 ADD bit7 (alu_sub=0)
  - 8 SUB bit8 (alu_sub=1)
  - 9 SHR bit9
  - 10 SHL bit10
  - 11 CLEAR bit11
  - 12-15 illegal.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch op, A (cmd_a or acc per cmd_use_acc) and B, clear the settle counter, go to EXEC.
  - EXEC: alu_sel/alu_sub/alu_a/alu_b driven from the latched command. The counter increments each cycle. On count==SETTLE_CYC-1:
    - Capture alu_res into rsp_data and the accumulator.
    - For CLEAR, capture 0 regardless of alu_res.
    - Go to RESP.
  - Illegal opcode: EXEC still lasts SETTLE_CYC cycles with alu_sel=0; rsp_data=0, rsp_err=1, accumulator unchanged.
  - RESP: rsp_valid=1, rsp_data/rsp_err stable. On rsp_ready, go to IDLE.
- cmd_ready is 0 outside IDLE. No back-to-back accept from RESP. One command is in flight at a time.
- Latency: command accepted at edge N; rsp_valid asserts after edge N+SETTLE_CYC; earliest next accept is one cycle after the response handshake.
- alu_sel=0, alu_sub=0, alu_a=alu_b=0 in IDLE and RESP, so no lane is selected.
- cmd_use_acc=1 reads the accumulator value current at the acceptance edge.
- Reset: asynchronous, any state returns to IDLE.
  - Reset values: cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, acc_out=0, alu_*=0.
  - A command in flight is discarded with no response.
- Arithmetic: results are WIDTH bits; carry/overflow from the ALU are not observed by this block.

Optional Feature:
- Macro ALU_SEQ_PERF_CNT_EN.
- When defined, adds outputs perf_ops (32-bit) and perf_errs (16-bit):
  - perf_ops counts completed response handshakes.
  - perf_errs counts handshakes with rsp_err=1.
  - Both saturate at all-ones and reset to 0.
- When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - the 12 one-hot select constants;
  - the opcode constants/enum;
  - the FSM state enum (IDLE, EXEC, RESP);
  - WIDTH/SEL_W defaults.
- Sub-module alu_op_decode is purely combinational: opcode in; one-hot sel, sub flag and illegal flag out. The mux and future controllers share it.

Test Plan:
- Reset values: assert rst_n=0 mid-EXEC → outputs at reset values next sample, no rsp_valid. Release, then op=7, a=0x0003, b=0x0004, mux returns 0x0007 → alu_sel=0x080, rsp_data=0x0007, acc_out=0x0007.
- Add/sub mode: op=8, a=0x0005, b=0x0007 with mux modeling SUB → alu_sub=1, alu_sel=0x100, rsp_data=0xFFFE.
- Accumulator chaining: op=0 with cmd_use_acc=1, acc=0x00F0, b=0x0F0F → alu_a=0x00F0, rsp_data=0x0000. Then op=11 → rsp_data=0, acc_out=0.
- Illegal opcode: op=13 → alu_sel=0 throughout, rsp_err=1, rsp_data=0, accumulator unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_data stable and cmd_ready=0 with cmd_valid held high. Release → exactly one handshake, then next command accepted.
- Latency: SETTLE_CYC=3 → rsp_valid first high 3 cycles after accept edge. With ALU_SEQ_PERF_CNT_EN, after 4 ops including 1 illegal → perf_ops=4, perf_errs=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, one-hot select and FSM state definitions for the ALU sequencer
//
// Purpose: common constants for alu_op_sequencer, alu_op_decode and the result mux.
// Contents: default datapath/select widths, opcode enum, one-hot lane selects,
//           sequencer FSM state enum.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SEL_W_DEF = 12;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_NOT   = 4'd2,
    OP_XOR   = 4'd3,
    OP_NAND  = 4'd4,
    OP_NOR   = 4'd5,
    OP_XNOR  = 4'd6,
    OP_ADD   = 4'd7,
    OP_SUB   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SHL   = 4'd10,
    OP_CLEAR = 4'd11
  } alu_op_e;

  // One-hot lane selects of the result multiplexer; opcodes 12..15 select no lane.
  localparam logic [SEL_W_DEF-1:0] SEL_AND   = 12'h001;
  localparam logic [SEL_W_DEF-1:0] SEL_OR    = 12'h002;
  localparam logic [SEL_W_DEF-1:0] SEL_NOT   = 12'h004;
  localparam logic [SEL_W_DEF-1:0] SEL_XOR   = 12'h008;
  localparam logic [SEL_W_DEF-1:0] SEL_NAND  = 12'h010;
  localparam logic [SEL_W_DEF-1:0] SEL_NOR   = 12'h020;
  localparam logic [SEL_W_DEF-1:0] SEL_XNOR  = 12'h040;
  localparam logic [SEL_W_DEF-1:0] SEL_ADD   = 12'h080;
  localparam logic [SEL_W_DEF-1:0] SEL_SUB   = 12'h100;
  localparam logic [SEL_W_DEF-1:0] SEL_SHR   = 12'h200;
  localparam logic [SEL_W_DEF-1:0] SEL_SHL   = 12'h400;
  localparam logic [SEL_W_DEF-1:0] SEL_CLEAR = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode decoder for the ALU result mux
//
// Purpose: maps a 4-bit opcode to the one-hot mux select, the add/sub mode
//          and an illegal-opcode flag. Shared by the sequencer and the mux.
// Ports:
//   op_i      in  4       opcode
//   sel_o     out SEL_W   one-hot lane select (0 for illegal opcodes)
//   sub_o     out 1       1 = subtract mode for the add/sub unit
//   illegal_o out 1       opcode is outside 0..11
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0]           op_i,
  output logic [SEL_W_DEF-1:0] sel_o,
  output logic                 sub_o,
  output logic                 illegal_o
);

  always_comb begin
    sel_o     = '0;
    sub_o     = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND:   sel_o = SEL_AND;
      OP_OR:    sel_o = SEL_OR;
      OP_NOT:   sel_o = SEL_NOT;
      OP_XOR:   sel_o = SEL_XOR;
      OP_NAND:  sel_o = SEL_NAND;
      OP_NOR:   sel_o = SEL_NOR;
      OP_XNOR:  sel_o = SEL_XNOR;
      OP_ADD:   sel_o = SEL_ADD;
      OP_SUB: begin
        sel_o = SEL_SUB;
        sub_o = 1'b1;
      end
      OP_SHR:   sel_o = SEL_SHR;
      OP_SHL:   sel_o = SEL_SHL;
      OP_CLEAR: sel_o = SEL_CLEAR;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command sequencer driving the ALU datapath and capturing the mux result
//
// Purpose: accepts one opcode+operands per cmd handshake, drives the ALU select,
//          mode and operands for SETTLE_CYC cycles, captures the mux result into
//          the accumulator and returns it on the rsp channel.
// Optional: define ALU_SEQ_PERF_CNT_EN to add saturating perf_ops/perf_errs counters.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_a, cmd_b, cmd_use_acc command fields (use_acc: A from accumulator)
//   alu_a, alu_b, alu_sub, alu_sel   ALU operand/mode/one-hot select outputs
//   alu_res                          result mux input
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_err                captured result, illegal-opcode flag
//   acc_out                          current accumulator
//   perf_ops, perf_errs              (ALU_SEQ_PERF_CNT_EN only) handshake counters
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SEL_W      = SEL_W_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sub,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc_out
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [15:0]      perf_errs
`endif
);

  // Settle counter reaches this value on the last EXEC cycle.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [SEL_W_DEF-1:0] dec_sel;
  logic                 dec_sub;
  logic                 dec_ill;

  // Decodes the latched opcode, so the select is stable for the whole EXEC window.
  alu_op_decode u_decode (
    .op_i      (op_q),
    .sel_o     (dec_sel),
    .sub_o     (dec_sub),
    .illegal_o (dec_ill)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_sel    = '0;
    alu_sub    = 1'b0;
    alu_a      = '0;
    alu_b      = '0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_use_acc ? acc_q : cmd_a;
          b_d     = cmd_b;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Illegal opcodes decode to an all-zero select, so no lane is driven.
        alu_sel = SEL_W'(dec_sel);
        alu_sub = dec_sub;
        alu_a   = a_q;
        alu_b   = b_q;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          if (dec_ill) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else if (op_q == OP_CLEAR) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            acc_d      = '0;
          end else begin
            rsp_data_d = alu_res;
            rsp_err_d  = 1'b0;
            acc_d      = alu_res;
          end
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign acc_out  = acc_q;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic        rsp_hs;
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [15:0] perf_errs_q, perf_errs_d;

  assign rsp_hs = rsp_valid & rsp_ready;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_errs_d = perf_errs_q;
    if (rsp_hs) begin
      if (perf_ops_q != '1) begin
        perf_ops_d = perf_ops_q + 32'd1;
      end
      if (rsp_err_q && (perf_errs_q != '1)) begin
        perf_errs_d = perf_errs_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q  <= '0;
      perf_errs_q <= '0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_errs_q <= perf_errs_d;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_errs = perf_errs_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        cmd_use_acc;
  logic [15:0] alu_a, alu_b, alu_res;
  logic        alu_sub;
  logic [11:0] alu_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data, acc_out;

  logic        cmd_valid3, cmd_ready3;
  logic [15:0] alu_a3, alu_b3, alu_res3;
  logic        alu_sub3;
  logic [11:0] alu_sel3;
  logic        rsp_valid3, rsp_ready3, rsp_err3;
  logic [15:0] rsp_data3, acc_out3;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [31:0] perf_ops, perf_ops3;
  logic [15:0] perf_errs, perf_errs3;
`endif

  int total = 0;
  int bad   = 0;
  int n_hs  = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural result mux: CLEAR and "no lane" return junk so forced zeros are visible.
  function automatic logic [15:0] mux_model(input logic [11:0] sel, input logic [15:0] a,
                                            input logic [15:0] b);
    case (sel)
      12'h001: return a & b;
      12'h002: return a | b;
      12'h004: return ~a;
      12'h008: return a ^ b;
      12'h010: return ~(a & b);
      12'h020: return ~(a | b);
      12'h040: return ~(a ^ b);
      12'h080: return a + b;
      12'h100: return a - b;
      12'h200: return a >> 1;
      12'h400: return a << 1;
      12'h800: return 16'hDEAD;
      default: return 16'hBEEF;
    endcase
  endfunction

  assign alu_res  = mux_model(alu_sel, alu_a, alu_b);
  assign alu_res3 = mux_model(alu_sel3, alu_a3, alu_b3);

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_sel(alu_sel),
    .alu_res(alu_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .acc_out(acc_out)
`ifdef ALU_SEQ_PERF_CNT_EN
    , .perf_ops(perf_ops), .perf_errs(perf_errs)
`endif
  );

  alu_op_sequencer #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sub(alu_sub3), .alu_sel(alu_sel3),
    .alu_res(alu_res3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .rsp_err(rsp_err3), .acc_out(acc_out3)
`ifdef ALU_SEQ_PERF_CNT_EN
    , .perf_ops(perf_ops3), .perf_errs(perf_errs3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        use_acc;
    logic [11:0] exp_sel;
    logic        exp_sub;
    logic [15:0] exp_alu_a;
    logic [15:0] exp_data;
    logic        exp_err;
    logic [15:0] exp_acc;
  } vec_t;

  vec_t vecs[16];

  task automatic run_cmd(input vec_t v);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = v.op;
    cmd_a       = v.a;
    cmd_b       = v.b;
    cmd_use_acc = v.use_acc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("exec_alu_sel", {20'd0, alu_sel}, {20'd0, v.exp_sel});
    chk("exec_alu_sub", {31'd0, alu_sub}, {31'd0, v.exp_sub});
    chk("exec_alu_a", {16'd0, alu_a}, {16'd0, v.exp_alu_a});
    chk("exec_alu_b", {16'd0, alu_b}, {16'd0, v.b});
    wait_rsp();
    chk("rsp_data", {16'd0, rsp_data}, {16'd0, v.exp_data});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk("acc_out", {16'd0, acc_out}, {16'd0, v.exp_acc});
    chk("resp_alu_sel", {20'd0, alu_sel}, 32'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    n_hs++;
    if (v.exp_err) n_err++;
    chk("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_valid3  = 1'b0;
    rsp_ready   = 1'b0;
    rsp_ready3  = 1'b0;
    cmd_op      = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_use_acc = 1'b0;

    //                 op     a        b        acc  sel      sub  alu_a    data     err  acc
    vecs[0]  = '{4'd7,  16'h0003, 16'h0004, 1'b0, 12'h080, 1'b0, 16'h0003, 16'h0007, 1'b0, 16'h0007};
    vecs[1]  = '{4'd8,  16'h0005, 16'h0007, 1'b0, 12'h100, 1'b1, 16'h0005, 16'hFFFE, 1'b0, 16'hFFFE};
    vecs[2]  = '{4'd1,  16'h00F0, 16'h0000, 1'b0, 12'h002, 1'b0, 16'h00F0, 16'h00F0, 1'b0, 16'h00F0};
    vecs[3]  = '{4'd0,  16'h1234, 16'h0F0F, 1'b1, 12'h001, 1'b0, 16'h00F0, 16'h0000, 1'b0, 16'h0000};
    vecs[4]  = '{4'd7,  16'hFFFF, 16'h0002, 1'b0, 12'h080, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0001};
    vecs[5]  = '{4'd13, 16'h1111, 16'h2222, 1'b0, 12'h000, 1'b0, 16'h1111, 16'h0000, 1'b1, 16'h0001};
    vecs[6]  = '{4'd11, 16'h5555, 16'hAAAA, 1'b0, 12'h800, 1'b0, 16'h5555, 16'h0000, 1'b0, 16'h0000};
    vecs[7]  = '{4'd2,  16'h0F0F, 16'h0000, 1'b0, 12'h004, 1'b0, 16'h0F0F, 16'hF0F0, 1'b0, 16'hF0F0};
    vecs[8]  = '{4'd10, 16'h0000, 16'h0000, 1'b1, 12'h400, 1'b0, 16'hF0F0, 16'hE1E0, 1'b0, 16'hE1E0};
    vecs[9]  = '{4'd9,  16'h8001, 16'h0000, 1'b0, 12'h200, 1'b0, 16'h8001, 16'h4000, 1'b0, 16'h4000};
    vecs[10] = '{4'd6,  16'hFF00, 16'h0FF0, 1'b0, 12'h040, 1'b0, 16'hFF00, 16'h0F0F, 1'b0, 16'h0F0F};
    vecs[11] = '{4'd15, 16'h0000, 16'h0000, 1'b0, 12'h000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0F0F};
    vecs[12] = '{4'd3,  16'h00FF, 16'h0F0F, 1'b0, 12'h008, 1'b0, 16'h00FF, 16'h0FF0, 1'b0, 16'h0FF0};
    vecs[13] = '{4'd4,  16'hFFFF, 16'h00FF, 1'b0, 12'h010, 1'b0, 16'hFFFF, 16'hFF00, 1'b0, 16'hFF00};
    vecs[14] = '{4'd5,  16'hF000, 16'h0F00, 1'b0, 12'h020, 1'b0, 16'hF000, 16'h00FF, 1'b0, 16'h00FF};
    vecs[15] = '{4'd12, 16'hABCD, 16'h0001, 1'b0, 12'h000, 1'b0, 16'hABCD, 16'h0000, 1'b1, 16'h00FF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_acc_out", {16'd0, acc_out}, 32'd0);
    chk("rst_alu_sel", {20'd0, alu_sel}, 32'd0);
    chk("rst_alu_ops", {alu_a, alu_b}, 32'd0);
    chk("rst_alu_sub", {31'd0, alu_sub}, 32'd0);

    // Give the accumulator a value, then reset in the middle of an ADD.
    run_cmd('{4'd1, 16'h00AA, 16'h0000, 1'b0, 12'h002, 1'b0, 16'h00AA, 16'h00AA, 1'b0, 16'h00AA});
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 4'd7; cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_use_acc = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("midexec_alu_sel", {20'd0, alu_sel}, 32'h080);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_alu_sel", {20'd0, alu_sel}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_acc_out", {16'd0, acc_out}, 32'd0);
    n_hs = 0;
    n_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_no_rsp", {31'd0, rsp_valid}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_cmd(vecs[i]);
    end

    // Backpressure: response held for 5 cycles while a new command waits.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 4'd1; cmd_a = 16'h00AA; cmd_b = 16'h5500; cmd_use_acc = 1'b0;
    @(posedge clk);
    #1;
    cmd_op = 4'd7; cmd_a = 16'h0001; cmd_b = 16'h0001;
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_data", {16'd0, rsp_data}, 32'h55AA);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    n_hs++;
    chk("bp_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("bp_next_accept", {31'd0, cmd_ready}, 32'd0);
    chk("bp_next_sel", {20'd0, alu_sel}, 32'h080);
    wait_rsp();
    chk("bp_next_data", {16'd0, rsp_data}, 32'h0002);
    chk("bp_next_acc", {16'd0, acc_out}, 32'h0002);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    n_hs++;

    // Latency with a 3-cycle settle window.
    @(negedge clk);
    cmd_valid3 = 1'b1;
    cmd_op = 4'd7; cmd_a = 16'h000A; cmd_b = 16'h0014; cmd_use_acc = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid3 = 1'b0;
    chk("s3_accept_ready", {31'd0, cmd_ready3}, 32'd0);
    lat = 0;
    while (!rsp_valid3 && lat < 20) begin
      chk("s3_exec_sel", {20'd0, alu_sel3}, 32'h080);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("s3_latency", lat, 32'd3);
    chk("s3_rsp_data", {16'd0, rsp_data3}, 32'h001E);
    chk("s3_acc_out", {16'd0, acc_out3}, 32'h001E);
    @(negedge clk);
    rsp_ready3 = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready3 = 1'b0;
    chk("s3_post_hs_ready", {31'd0, cmd_ready3}, 32'd1);

`ifdef ALU_SEQ_PERF_CNT_EN
    chk("perf_ops", perf_ops, n_hs);
    chk("perf_errs", {16'd0, perf_errs}, n_err);
    chk("perf_ops3", perf_ops3, 32'd1);
    chk("perf_errs3", {16'd0, perf_errs3}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
